alu_issue_ctrl: RTL and testbench

Sequential decode/issue/writeback controller that drives the combinational `alu_simple` datapath. It accepts 32-bit instructions over a valid/ready handshake and decodes them into the ALU control fields (Opcode, S, SR_Cont, SR_Bit, Immediate). It reads operands from an internal 8x32 register file, captures the ALU result and flags, and writes back. It is the producer side of the ALU control interface and sits between instruction fetch and `alu_simple`.

---
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Decode/issue/writeback controller for the alu_simple datapath.
// Two-state FSM: accept and decode in IDLE, write the ALU result back in EXEC.
module alu_issue_ctrl #(
   parameter logic [3:0] FLAG_RST = 4'h0
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Instr_Valid,
   input  logic [31:0] Instr,
   output logic        Instr_Ready,
   output logic [31:0] Alu_In1,
   output logic [31:0] Alu_In2,
   output logic [3:0]  Alu_Opcode,
   output logic        Alu_S,
   output logic [2:0]  Alu_SR_Cont,
   output logic [4:0]  Alu_SR_Bit,
   output logic [15:0] Alu_Immediate,
   input  logic [31:0] Alu_Out,
   input  logic [3:0]  Alu_Flags,
   output logic [31:0] Result,
   output logic        Done,
   output logic        Err,
   output logic [3:0]  Flags,
   input  logic [2:0]  Dbg_Addr,
   output logic [31:0] Dbg_Data
);

   localparam logic       StIdle   = 1'b0;
   localparam logic       StExec   = 1'b1;
   localparam logic [3:0] OpMovImm = 4'b0110;

   logic        state_q, state_d;
   logic [31:0] rf_q [8];
   logic [2:0]  rd_q;
   logic [31:0] in1_q, in2_q;
   logic [3:0]  opcode_q;
   logic        s_q;
   logic [2:0]  sr_cont_q;
   logic [4:0]  sr_bit_q;
   logic [15:0] imm_q;
   logic [31:0] result_q;
   logic        done_q, err_q;
   logic [3:0]  flags_q;

   logic        accept;
   logic        is_mov_imm;
   logic        in_exec;
   logic        wb_en;

   assign accept     = (state_q == StIdle) && Instr_Valid;
   assign is_mov_imm = (Instr[31:28] == OpMovImm);
   assign in_exec    = (state_q == StExec);
   // Opcodes with the top bit set are illegal.
   assign wb_en      = in_exec && !opcode_q[3];

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (Instr_Valid) state_d = StExec;
         StExec:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= StIdle;
         rd_q      <= '0;
         in1_q     <= '0;
         in2_q     <= '0;
         opcode_q  <= '0;
         s_q       <= 1'b0;
         sr_cont_q <= '0;
         sr_bit_q  <= '0;
         imm_q     <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         flags_q   <= FLAG_RST;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (accept) begin
            opcode_q  <= Instr[31:28];
            s_q       <= Instr[27];
            sr_cont_q <= Instr[26:24];
            sr_bit_q  <= Instr[23:19];
            rd_q      <= Instr[18:16];
            if (is_mov_imm) begin
               in1_q <= '0;
               in2_q <= '0;
               imm_q <= Instr[15:0];
            end else begin
               in1_q <= rf_q[Instr[15:13]];
               in2_q <= rf_q[Instr[12:10]];
               imm_q <= '0;
            end
         end
         if (in_exec) begin
            if (opcode_q[3]) begin
               err_q <= 1'b1;
            end else begin
               result_q <= Alu_Out;
               done_q   <= 1'b1;
               if (s_q) flags_q <= Alu_Flags;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else if (wb_en) begin
         rf_q[rd_q] <= Alu_Out;
      end
   end

   assign Instr_Ready   = (state_q == StIdle);
   assign Alu_In1       = in1_q;
   assign Alu_In2       = in2_q;
   assign Alu_Opcode    = opcode_q;
   assign Alu_S         = s_q;
   assign Alu_SR_Cont   = sr_cont_q;
   assign Alu_SR_Bit    = sr_bit_q;
   assign Alu_Immediate = imm_q;
   assign Result        = result_q;
   assign Done          = done_q;
   assign Err           = err_q;
   assign Flags         = flags_q;
   assign Dbg_Data      = rf_q[Dbg_Addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand sequences
// and random instructions against a register-file level reference model.
module tb_alu_issue_ctrl;

   localparam logic [3:0] FLAG_RST_TB = 4'hA;

   logic        clk, rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [31:0] alu_in1, alu_in2, alu_out, result, dbg_data;
   logic [3:0]  alu_opcode, alu_flags, flags;
   logic        alu_s, done, err;
   logic [2:0]  alu_sr_cont, dbg_addr;
   logic [4:0]  alu_sr_bit;
   logic [15:0] alu_immediate;

   int total = 0;
   int bad   = 0;

   logic [31:0] ref_rf [8];
   logic [31:0] ref_result;
   logic [3:0]  ref_flags;

   alu_issue_ctrl #(.FLAG_RST(FLAG_RST_TB)) dut (
      .Clk(clk), .Reset_n(rst_n), .Instr_Valid(instr_valid), .Instr(instr),
      .Instr_Ready(instr_ready), .Alu_In1(alu_in1), .Alu_In2(alu_in2),
      .Alu_Opcode(alu_opcode), .Alu_S(alu_s), .Alu_SR_Cont(alu_sr_cont),
      .Alu_SR_Bit(alu_sr_bit), .Alu_Immediate(alu_immediate), .Alu_Out(alu_out),
      .Alu_Flags(alu_flags), .Result(result), .Done(done), .Err(err), .Flags(flags),
      .Dbg_Addr(dbg_addr), .Dbg_Data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural alu_simple: returns {N, Z, C, V, result}.
   function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [2:0] sc,
                                          input logic [4:0] sb, input logic [15:0] imm);
      logic [31:0] sh, r;
      logic [32:0] w;
      logic        c, v;
      case (sc)
         3'b001:  sh = b >> sb;
         3'b010:  sh = b << sb;
         3'b011:  sh = (b >> sb) | (b << (6'd32 - {1'b0, sb}));
         3'b100:  sh = $signed(b) >>> sb;
         default: sh = b;
      endcase
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, sh};
            r = w[31:0];
            c = w[32];
            v = (a[31] == sh[31]) && (r[31] != a[31]);
         end
         4'd1: begin
            r = a - sh;
            c = (a >= sh);
            v = (a[31] != sh[31]) && (r[31] != a[31]);
         end
         4'd2:    r = a * sh;
         4'd3:    r = a | sh;
         4'd4:    r = a & sh;
         4'd5:    r = a ^ sh;
         4'd6:    r = {16'h0, imm};
         4'd7:    r = sh;
         default: r = 32'h0;
      endcase
      return {r[31], (r == 32'h0), c, v, r};
   endfunction

   assign {alu_flags, alu_out} = alu_fn(alu_opcode, alu_in1, alu_in2, alu_sr_cont,
                                        alu_sr_bit, alu_immediate);

   function automatic logic [31:0] enc(input logic [3:0] op, input logic s,
                                       input logic [2:0] sc, input logic [4:0] sb,
                                       input logic [2:0] rd, input logic [2:0] rn,
                                       input logic [2:0] rm);
      return {op, s, sc, sb, rd, rn, rm, 10'h0};
   endfunction

   function automatic logic [31:0] enc_imm(input logic [2:0] rd, input logic [15:0] imm);
      return {4'b0110, 1'b0, 3'b000, 5'd0, rd, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 8; i++) ref_rf[i] = 32'h0;
      ref_result = 32'h0;
      ref_flags  = FLAG_RST_TB;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, instr_ready, 1);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_flags"}, flags, FLAG_RST_TB);
      check({tag, "_result"}, result, 0);
      check({tag, "_alu_op"}, {alu_opcode, alu_s, alu_sr_cont, alu_sr_bit}, 0);
      check({tag, "_alu_in"}, alu_in1 | alu_in2 | {16'h0, alu_immediate}, 0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check($sformatf("%s_rf%0d", tag, i), dbg_data, 0);
      end
   endtask

   task automatic idle();
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one instruction starting from an IDLE cycle; keep leaves Instr_Valid
   // high through EXEC, which must be ignored by the controller.
   task automatic run_instr(input logic [31:0] ins, input logic keep);
      logic [3:0]  op;
      logic [2:0]  rd, rn, rm;
      logic [31:0] e_in1, e_in2;
      logic [15:0] e_imm;
      logic [35:0] r;
      logic        legal;
      op    = ins[31:28];
      rd    = ins[18:16];
      rn    = ins[15:13];
      rm    = ins[12:10];
      legal = !op[3];
      e_in1 = (op == 4'd6) ? 32'h0 : ref_rf[rn];
      e_in2 = (op == 4'd6) ? 32'h0 : ref_rf[rm];
      e_imm = (op == 4'd6) ? ins[15:0] : 16'h0;
      r     = alu_fn(op, e_in1, e_in2, ins[26:24], ins[23:19], e_imm);

      check("ready_idle", instr_ready, 1);
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep) instr_valid = 1'b0;
      check("ready_exec", instr_ready, 0);
      check("done_exec", done, 0);
      check("err_exec", err, 0);
      check("alu_opcode", alu_opcode, op);
      check("alu_s", alu_s, ins[27]);
      check("alu_sr_cont", alu_sr_cont, ins[26:24]);
      check("alu_sr_bit", alu_sr_bit, ins[23:19]);
      check("alu_imm", alu_immediate, e_imm);
      check("alu_in1", alu_in1, e_in1);
      check("alu_in2", alu_in2, e_in2);
      @(posedge clk);
      @(negedge clk);
      if (legal) begin
         ref_rf[rd] = r[31:0];
         ref_result = r[31:0];
         if (ins[27]) ref_flags = r[35:32];
      end
      check("done_wb", done, legal);
      check("err_wb", err, !legal);
      check("result_wb", result, ref_result);
      check("flags_wb", flags, ref_flags);
      check("ready_wb", instr_ready, 1);
      check("alu_held", alu_opcode, op);
      dbg_addr = rd;
      #1;
      check("dbg_rd", dbg_data, ref_rf[rd]);
   endtask

   typedef struct {
      logic [31:0] ins;
      logic        keep;
      logic [31:0] exp_result;
      logic [3:0]  exp_flags;
      logic        exp_err;
   } vec_t;

   vec_t        vecs [19];
   logic [31:0] rnd_ins;
   logic [3:0]  rnd_op;

   initial begin
      vecs[0]  = '{enc_imm(3'd1, 16'd15), 1'b0, 32'd15, 4'hA, 1'b0};
      vecs[1]  = '{enc_imm(3'd2, 16'd20), 1'b0, 32'd20, 4'hA, 1'b0};
      vecs[2]  = '{enc(4'd0, 1'b1, 3'd0, 5'd0, 3'd3, 3'd1, 3'd2), 1'b0, 32'd35, 4'h0, 1'b0};
      vecs[3]  = '{enc(4'd1, 1'b1, 3'd0, 5'd0, 3'd6, 3'd1, 3'd2), 1'b0, 32'hFFFF_FFFB,
                   4'h8, 1'b0};
      vecs[4]  = '{enc_imm(3'd1, 16'd30), 1'b0, 32'd30, 4'h8, 1'b0};
      vecs[5]  = '{enc_imm(3'd2, 16'd10), 1'b0, 32'd10, 4'h8, 1'b0};
      vecs[6]  = '{enc(4'd0, 1'b0, 3'd1, 5'd4, 3'd3, 3'd1, 3'd2), 1'b0, 32'd30, 4'h8, 1'b0};
      vecs[7]  = '{enc(4'd0, 1'b0, 3'd2, 5'd4, 3'd3, 3'd1, 3'd2), 1'b0, 32'd190, 4'h8, 1'b0};
      vecs[8]  = '{enc(4'd0, 1'b0, 3'd3, 5'd4, 3'd3, 3'd1, 3'd2), 1'b0, 32'hA000_001E,
                   4'h8, 1'b0};
      vecs[9]  = '{enc(4'd1, 1'b0, 3'd0, 5'd0, 3'd3, 3'd1, 3'd2), 1'b0, 32'd20, 4'h8, 1'b0};
      vecs[10] = '{enc_imm(3'd4, 16'd5), 1'b0, 32'd5, 4'h8, 1'b0};
      vecs[11] = '{enc(4'd2, 1'b0, 3'd0, 5'd0, 3'd5, 3'd4, 3'd4), 1'b0, 32'd25, 4'h8, 1'b0};
      vecs[12] = '{enc_imm(3'd1, 16'h00FF), 1'b0, 32'h0FF, 4'h8, 1'b0};
      vecs[13] = '{enc_imm(3'd2, 16'h00F0), 1'b0, 32'h0F0, 4'h8, 1'b0};
      vecs[14] = '{enc(4'd5, 1'b0, 3'd0, 5'd0, 3'd3, 3'd1, 3'd2), 1'b0, 32'h00F, 4'h8, 1'b0};
      vecs[15] = '{enc(4'd9, 1'b1, 3'd0, 5'd0, 3'd3, 3'd1, 3'd2), 1'b0, 32'h00F, 4'h8, 1'b1};
      vecs[16] = '{enc_imm(3'd3, 16'd35), 1'b1, 32'd35, 4'h8, 1'b0};
      vecs[17] = '{enc(4'd0, 1'b0, 3'd0, 5'd0, 3'd4, 3'd3, 3'd3), 1'b1, 32'd70, 4'h8, 1'b0};
      vecs[18] = '{enc(4'd7, 1'b0, 3'd0, 5'd0, 3'd5, 3'd0, 3'd4), 1'b0, 32'd70, 4'h8, 1'b0};

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr       = 32'h0;
      dbg_addr    = 3'd0;
      reset_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state("reset");

      // Directed table; the last three rows run back-to-back with Instr_Valid held.
      for (int i = 0; i < 19; i++) begin
         run_instr(vecs[i].ins, vecs[i].keep);
         check($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
         check($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
         check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      end
      dbg_addr = 3'd3;
      #1;
      check("illegal_kept_r3", dbg_data, 32'd35);

      for (int n = 0; n < 60; n++) begin
         rnd_ins = $urandom;
         rnd_op  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15))
                                               : 4'($urandom_range(0, 7));
         rnd_ins[31:28] = rnd_op;
         if ($urandom_range(0, 3) == 0) idle();
         run_instr(rnd_ins, 1'($urandom_range(0, 1)));
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check($sformatf("rand_rf%0d", i), dbg_data, ref_rf[i]);
      end

      // Make sure some register is non-zero before aborting an instruction.
      @(negedge clk);
      run_instr(enc_imm(3'd1, 16'h1234), 1'b0);
      instr       = enc(4'd0, 1'b1, 3'd0, 5'd0, 3'd7, 3'd1, 3'd1);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      check("abort_in_exec", instr_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_ready_async", instr_ready, 1);
      check("abort_rf1_async", (dbg_addr == 3'd1) ? dbg_data : 32'h0, 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("abort_done_low", done, 0);
      end
      rst_n = 1'b1;
      reset_model();
      @(negedge clk);
      check("abort_no_done", done, 0);
      check_reset_state("abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
